uart_rx_kbd: RTL and testbench

- UART receiver that sits between the board-level `uart_rx` pin and the keyboard input port of the PIA in the apple1 core.
- Receives 8N1 serial data and holds each byte in a one-byte holding register.
- Presents the byte to the PIA over a valid/ready handshake.
- Drives `uart_cts` so the host pauses while an unread byte is pending.

---
 rtl/uart_rx_kbd.sv | 155 +++++++++++++++
 tb/tb_uart_rx_kbd.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_kbd.sv
// uart_rx_kbd: 8N1 UART receiver with a one-byte holding register and a
// valid/ready handshake toward the PIA keyboard port. uart_cts mirrors the
// holding-register-full state so the host pauses while a byte is unread.
module uart_rx_kbd #(
  parameter int CLKS_PER_BIT = 217,
  parameter int UPPERCASE    = 1
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_cts,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  localparam int          HALF_I = CLKS_PER_BIT / 2;
  localparam int          FULL_I = CLKS_PER_BIT - 1;
  localparam logic [15:0] HALF   = HALF_I[15:0];
  // Reload with N-1: the counter spends N cycles on N-1..0, so samples are
  // exactly one bit period apart with no cumulative drift across the frame.
  localparam logic [15:0] FULL_M1 = FULL_I[15:0];

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        cts_q;

  logic        rx_s;
  logic        tick;
  logic        consume;
  logic        byte_done;
  logic        bad_stop;
  logic [7:0]  mapped;

  assign rx_s      = sync2_q;
  assign tick      = (cnt_q == 16'd0);
  assign consume   = valid_q & rx_ready;
  assign byte_done = (state_q == S_STOP) & tick & rx_s;
  assign bad_stop  = (state_q == S_STOP) & tick & ~rx_s;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
    end
  end

  // State register
  always_ff @(posedge clk25) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: if (tick) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (tick && idx_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (tick) state_d = rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: bit timing, shift register, holding register and sticky flags
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    mapped  = sh_q;
    if (UPPERCASE != 0 && sh_q >= 8'h61 && sh_q <= 8'h7A) mapped = sh_q - 8'h20;

    case (state_q)
      S_IDLE: begin
        cnt_d = HALF;
        idx_d = 3'd0;
      end
      S_START, S_DATA, S_STOP: begin
        cnt_d = tick ? FULL_M1 : cnt_q - 16'd1;
        if (state_q == S_DATA && tick) begin
          sh_d  = {rx_s, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
        end
      end
      default: cnt_d = 16'd0;
    endcase

    // Clears first so that a same-cycle set wins
    if (consume) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
    if (byte_done) begin
      if (!valid_q || rx_ready) begin
        data_d  = mapped;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (bad_stop) ferr_d = 1'b1;
  end

  // Datapath registers; cts tracks the holding register after the same edge
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      sh_q    <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cts_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      cts_q   <= valid_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign uart_cts  = cts_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_kbd.sv
// Bench for uart_rx_kbd: directed scenarios plus random frames, checked
// against a frame-level model of the holding register and sticky flags.
module tb_uart_rx_kbd;
  localparam int C = 10;

  logic       clk25 = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       uart_cts, rx_valid, frame_err, overrun;
  logic [7:0] rx_data;
  logic       lc_cts, lc_valid, lc_ferr, lc_ovr;
  logic [7:0] lc_data;

  int passed = 0;
  int total  = 0;

  // Frame-level model
  logic       m_valid, m_ferr, m_ovr;
  logic [7:0] m_data_u, m_data_l;
  logic [7:0] recv[$];

  always #20 clk25 = ~clk25;

  uart_rx_kbd #(.CLKS_PER_BIT(C), .UPPERCASE(1)) u_dut (
    .clk25(clk25), .rst_n(rst_n), .uart_rx(uart_rx), .uart_cts(uart_cts),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun));

  uart_rx_kbd #(.CLKS_PER_BIT(C), .UPPERCASE(0)) u_dut_lc (
    .clk25(clk25), .rst_n(rst_n), .uart_rx(uart_rx), .uart_cts(lc_cts),
    .rx_data(lc_data), .rx_valid(lc_valid), .rx_ready(rx_ready),
    .frame_err(lc_ferr), .overrun(lc_ovr));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk25);
  endtask

  function automatic logic [7:0] upcase(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
  endfunction

  task automatic m_reset();
    m_valid = 0; m_ferr = 0; m_ovr = 0; m_data_u = 0; m_data_l = 0;
  endtask

  task automatic m_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) m_ferr = 1;
    else if (!m_valid) begin
      m_valid = 1; m_data_u = upcase(b); m_data_l = b;
    end else m_ovr = 1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 0; clks(n); rst_n = 1; m_reset();
  endtask

  // Drives one frame; the line is left at the stop level afterwards
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 0; clks(C);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; clks(C); end
    uart_rx = stop_bit; clks(C);
  endtask

  task automatic send_idle(input logic [7:0] b);
    send_frame(b, 1'b1); clks(2 * C); m_frame(b, 1'b1);
  endtask

  task automatic consume();
    rx_ready = 1; clks(1); rx_ready = 0;
    if (m_valid) begin m_valid = 0; m_ferr = 0; m_ovr = 0; end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {7'd0, rx_valid}, {7'd0, m_valid});
    check({tag, ".cts"}, {7'd0, uart_cts}, {7'd0, m_valid});
    check({tag, ".ferr"}, {7'd0, frame_err}, {7'd0, m_ferr});
    check({tag, ".ovr"}, {7'd0, overrun}, {7'd0, m_ovr});
    check({tag, ".data"}, rx_data, m_data_u);
    check({tag, ".data_lc"}, lc_data, m_data_l);
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;
    // reset
    m_reset();
    clks(1); do_reset(3); clks(1);
    check_all("reset");

    // basic 0x41 and handshake
    send_idle(8'h41);
    check_all("byte41");
    consume(); clks(1);
    check_all("consume41");

    // uppercase mapping, and bit 7 bypasses it
    send_idle(8'h61);
    check_all("lower61");
    consume();
    send_idle(8'hE1);
    check_all("highE1");
    consume();

    // ready while empty is ignored
    consume(); clks(1);
    check_all("idle_ready");

    // overrun
    send_idle(8'h31);
    send_idle(8'h32);
    check_all("overrun");
    consume(); clks(1);
    check_all("ovr_clear");

    // framing error then break held low
    send_frame(8'h55, 1'b0); m_frame(8'h55, 1'b0);
    uart_rx = 0; clks(3 * C);
    check_all("break_low");
    uart_rx = 1; clks(2 * C);
    check_all("break_rel");
    send_idle(8'h0D);
    check_all("after_brk");
    consume(); clks(1);
    check_all("ferr_clear");

    // glitch on idle line
    uart_rx = 0; clks(3); uart_rx = 1; clks(2 * C);
    check_all("glitch");

    // reset during bit 4; the leftover bits are all ones
    send_idle(8'h41);
    b = {4'hF, 4'($urandom_range(0, 15))};
    uart_rx = 0; clks(C);
    for (int i = 0; i < 4; i++) begin uart_rx = b[i]; clks(C); end
    uart_rx = 1; clks(2);
    do_reset(1);
    check_all("mid_rst");
    clks(C - 3 + 3 * C);
    uart_rx = 1; clks(3 * C);
    check_all("post_rst");
    send_idle(8'h41);
    check_all("rst_41");
    consume();

    // back-to-back frames, consumer reacting within a couple of cycles
    recv.delete();
    fork
      begin
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          ok = 0;
          for (int t = 0; t < 30 * C && !ok; t++) begin
            clks(1);
            if (rx_valid) ok = 1;
          end
          check("b2b.wait", {7'd0, ok}, 8'd1);
          recv.push_back(rx_data);
          rx_ready = 1; clks(1); rx_ready = 0;
        end
      end
    join
    clks(2 * C);
    check("b2b.n", 8'(recv.size()), 8'd2);
    if (recv.size() == 2) begin
      check("b2b.0", recv[0], 8'h41);
      check("b2b.1", recv[1], 8'h42);
    end
    check("b2b.ferr", {7'd0, frame_err}, 8'd0);
    check("b2b.ovr", {7'd0, overrun}, 8'd0);
    check("b2b.valid", {7'd0, rx_valid}, 8'd0);
    m_reset();

    // random frames with random consumes and occasional bad stop bits
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok);
      uart_rx = 1; clks(2 * C);
      m_frame(b, ok);
      check_all("rand");
      if ($urandom_range(0, 1) == 1) begin
        consume(); clks(1);
        check_all("rand_cons");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
